// File: rtl/cim_seq_ctrl.sv
// rtl/cim_seq_ctrl.sv - RV32I micro-sequencer for the CIM register-file control port (option: CIM_SEQ_TIMEOUT_EN)
module cim_seq_ctrl #(
   parameter int COLS        = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   input  logic [COLS-1:0] pc,
   input  logic            mem_ack,
   input  logic            buffer_carry_out,
   output logic [4:0]      rd_index,
   output logic [4:0]      rs1_index,
   output logic [4:0]      rs2_index,
   output logic            write_en,
   output logic            op_enable,
   output logic            data2bus_en,
   output logic            exp_go_up,
   output logic            exp_go_dn,
   output logic            buffer_read,
   output logic            buffer_write,
   output logic            inv_en,
   output logic            imm_en,
   output logic            imm_up_en,
   output logic            pc_imm_en,
   output logic            pc_plus_en,
   output logic            dataFM_en,
   output logic            carry_in,
   output logic [3:0]      op_fa,
   output logic [COLS-1:0] immediate,
   output logic [COLS-1:0] pc_reg,
   output logic [COLS-1:0] pc_plus4,
   output logic            mem_req,
   output logic            mem_we,
   output logic            done,
   output logic            illegal,
   output logic            mem_err,
   output logic            carry_flag
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_EXEC2,
      S_MEM_WAIT,
      S_WB
   } state_t;

   typedef enum logic [2:0] {
      K_ALU_R,
      K_ALU_I,
      K_SUB,
      K_LUI,
      K_AUIPC,
      K_LW,
      K_SW,
      K_ILL
   } kind_t;

   // Everything the array sees in one cycle, registered as one word
   typedef struct packed {
      logic       write_en;
      logic       op_enable;
      logic       data2bus_en;
      logic       exp_go_up;
      logic       exp_go_dn;
      logic       buffer_read;
      logic       buffer_write;
      logic       inv_en;
      logic       imm_en;
      logic       imm_up_en;
      logic       pc_imm_en;
      logic       pc_plus_en;
      logic       data_fm_en;
      logic       carry_in;
      logic [3:0] op_fa;
      logic       mem_req;
      logic       mem_we;
   } strb_t;

   state_t          r_state;
   kind_t           r_kind;
   logic [3:0]      r_fa;
   logic            r_wr_ok;
   strb_t           r_strb;
   logic            r_done;
   logic            r_illegal;
   logic            r_carry;
   logic [4:0]      r_rd;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [COLS-1:0] r_imm;
   logic [COLS-1:0] r_pc;
   logic [COLS-1:0] r_pc4;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic            w_alu_f3;
   logic            w_rd_nz;
   kind_t           w_kind;
   logic [3:0]      w_fa;
   logic [COLS-1:0] w_imm;
   logic            w_sw_done;

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];
   assign w_funct7 = instr[31:25];
   assign w_rd_nz  = |instr[11:7];
   assign w_alu_f3 = (w_funct3 == 3'b000) || (w_funct3 == 3'b100) ||
                     (w_funct3 == 3'b110) || (w_funct3 == 3'b111);

   // Classify the incoming word; anything not recognised is illegal
   always_comb begin
      w_kind = K_ILL;
      case (w_opcode)
         7'b0110011: begin
            if (w_funct7 == 7'b0000000 && w_alu_f3)
               w_kind = K_ALU_R;
            else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000)
               w_kind = K_SUB;
         end
         7'b0010011: begin
            if (w_alu_f3)
               w_kind = K_ALU_I;
         end
         7'b0110111: w_kind = K_LUI;
         7'b0010111: w_kind = K_AUIPC;
         7'b0000011: begin
            if (w_funct3 == 3'b010)
               w_kind = K_LW;
         end
         7'b0100011: begin
            if (w_funct3 == 3'b010)
               w_kind = K_SW;
         end
         default: w_kind = K_ILL;
      endcase
   end

   // funct3 to one-hot full-adder operation select
   always_comb begin
      w_fa = 4'b0000;
      case (w_funct3)
         3'b000:  w_fa = 4'b0001;
         3'b111:  w_fa = 4'b0010;
         3'b100:  w_fa = 4'b0100;
         3'b110:  w_fa = 4'b1000;
         default: w_fa = 4'b0000;
      endcase
   end

   // Immediate format follows the opcode: U for LUI/AUIPC, S for stores, I otherwise
   always_comb begin
      w_imm = COLS'($signed(instr[31:20]));
      case (w_opcode)
         7'b0110111, 7'b0010111: w_imm = COLS'($signed({instr[31:12], 12'b0}));
         7'b0100011:             w_imm = COLS'($signed({instr[31:25], instr[11:7]}));
         default:                w_imm = COLS'($signed(instr[31:20]));
      endcase
   end

   // Strobe set the array must see while the sequencer sits in state st
   function automatic strb_t f_strobes(input state_t st, input kind_t k,
                                       input logic [3:0] fa, input logic wr_ok);
      strb_t s;
      s = '0;
      case (st)
         S_EXEC, S_MEM_WAIT: begin
            case (k)
               K_ALU_R: begin
                  s.op_enable   = 1'b1;
                  s.write_en    = 1'b1;
                  s.data2bus_en = 1'b1;
                  s.op_fa       = fa;
               end
               K_ALU_I: begin
                  s.op_enable = 1'b1;
                  s.write_en  = 1'b1;
                  s.imm_en    = 1'b1;
                  s.op_fa     = fa;
               end
               K_SUB: begin
                  // first half of SUB parks ~rs2 in the buffer row
                  s.inv_en       = 1'b1;
                  s.op_fa        = 4'b0100;
                  s.data2bus_en  = 1'b1;
                  s.buffer_write = 1'b1;
               end
               K_LUI: begin
                  s.imm_up_en = 1'b1;
                  s.write_en  = 1'b1;
               end
               K_AUIPC: begin
                  s.pc_imm_en = 1'b1;
                  s.write_en  = 1'b1;
               end
               K_LW, K_SW: begin
                  s.exp_go_up = 1'b1;
                  s.op_enable = 1'b1;
                  s.imm_en    = 1'b1;
                  s.op_fa     = 4'b0001;
                  s.mem_req   = 1'b1;
                  if (k == K_SW) begin
                     s.data2bus_en = 1'b1;
                     s.mem_we      = 1'b1;
                  end
               end
               default: s = '0;
            endcase
         end
         S_EXEC2: begin
            // rs1 + ~rs2 + 1 completes the subtraction
            s.op_enable   = 1'b1;
            s.buffer_read = 1'b1;
            s.op_fa       = 4'b0001;
            s.carry_in    = 1'b1;
            s.write_en    = 1'b1;
         end
         S_WB: begin
            s.data_fm_en = 1'b1;
            s.write_en   = 1'b1;
         end
         default: s = '0;
      endcase
      if (!wr_ok)
         s.write_en = 1'b0;
      return s;
   endfunction

`ifdef CIM_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_mem_err;
`else
   logic             w_unused_timeout;
   assign w_unused_timeout = (MEM_TIMEOUT == 0);
`endif

   // Sequencer: state, latched instruction context and next-cycle strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_kind    <= K_ALU_R;
         r_fa      <= 4'b0000;
         r_wr_ok   <= 1'b0;
         r_strb    <= '0;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         r_carry   <= 1'b0;
         r_rd      <= 5'd0;
         r_rs1     <= 5'd0;
         r_rs2     <= 5'd0;
         r_imm     <= '0;
         r_pc      <= '0;
         r_pc4     <= '0;
`ifdef CIM_SEQ_TIMEOUT_EN
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
`endif
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
`ifdef CIM_SEQ_TIMEOUT_EN
         r_mem_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_state   <= S_EXEC;
                  r_kind    <= w_kind;
                  r_fa      <= w_fa;
                  r_wr_ok   <= w_rd_nz;
                  r_rd      <= instr[11:7];
                  r_rs1     <= instr[19:15];
                  r_rs2     <= instr[24:20];
                  r_imm     <= w_imm;
                  r_pc      <= pc;
                  r_pc4     <= pc + COLS'(4);
                  r_strb    <= f_strobes(S_EXEC, w_kind, w_fa, w_rd_nz);
                  r_done    <= (w_kind == K_ALU_R) || (w_kind == K_ALU_I) ||
                               (w_kind == K_LUI)   || (w_kind == K_AUIPC);
                  r_illegal <= (w_kind == K_ILL);
               end
            end
            S_EXEC: begin
               case (r_kind)
                  K_SUB: begin
                     r_state <= S_EXEC2;
                     r_strb  <= f_strobes(S_EXEC2, r_kind, r_fa, r_wr_ok);
                     r_done  <= 1'b1;
                  end
                  K_LW, K_SW: begin
                     r_state <= S_MEM_WAIT;
                     r_strb  <= f_strobes(S_MEM_WAIT, r_kind, r_fa, r_wr_ok);
`ifdef CIM_SEQ_TIMEOUT_EN
                     r_wait_cnt <= '0;
`endif
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_strb  <= '0;
                  end
               endcase
            end
            S_EXEC2: begin
               r_carry <= buffer_carry_out;
               r_state <= S_IDLE;
               r_strb  <= '0;
            end
            S_MEM_WAIT: begin
               if (mem_ack) begin
                  if (r_kind == K_LW) begin
                     r_state <= S_WB;
                     r_strb  <= f_strobes(S_WB, r_kind, r_fa, r_wr_ok);
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_strb  <= '0;
                  end
               end
`ifdef CIM_SEQ_TIMEOUT_EN
               else if (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                  r_state   <= S_IDLE;
                  r_strb    <= '0;
                  r_mem_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
`endif
            end
            S_WB: begin
               r_state <= S_IDLE;
               r_strb  <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_strb  <= '0;
            end
         endcase
      end
   end

   // A store retires in the cycle its acknowledge arrives, so done cannot wait for the edge
   assign w_sw_done = (r_state == S_MEM_WAIT) && (r_kind == K_SW) && mem_ack && !rst;

   assign instr_ready  = (r_state == S_IDLE);
   assign write_en     = r_strb.write_en;
   assign op_enable    = r_strb.op_enable;
   assign data2bus_en  = r_strb.data2bus_en;
   assign exp_go_up    = r_strb.exp_go_up;
   assign exp_go_dn    = r_strb.exp_go_dn;
   assign buffer_read  = r_strb.buffer_read;
   assign buffer_write = r_strb.buffer_write;
   assign inv_en       = r_strb.inv_en;
   assign imm_en       = r_strb.imm_en;
   assign imm_up_en    = r_strb.imm_up_en;
   assign pc_imm_en    = r_strb.pc_imm_en;
   assign pc_plus_en   = r_strb.pc_plus_en;
   assign dataFM_en    = r_strb.data_fm_en;
   assign carry_in     = r_strb.carry_in;
   assign op_fa        = r_strb.op_fa;
   assign mem_req      = r_strb.mem_req;
   assign mem_we       = r_strb.mem_we;
   assign done         = r_done | w_sw_done;
   assign illegal      = r_illegal;
   assign carry_flag   = r_carry;
   assign rd_index     = r_rd;
   assign rs1_index    = r_rs1;
   assign rs2_index    = r_rs2;
   assign immediate    = r_imm;
   assign pc_reg       = r_pc;
   assign pc_plus4     = r_pc4;
`ifdef CIM_SEQ_TIMEOUT_EN
   assign mem_err      = r_mem_err;
`else
   assign mem_err      = 1'b0;
`endif

endmodule

// File: tb/tb_cim_seq_ctrl.sv
// tb/tb_cim_seq_ctrl.sv - randomized self-checking bench for cim_seq_ctrl
`timescale 1ns/1ps
module tb_cim_seq_ctrl;

   localparam int COLS = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr;
   logic [COLS-1:0] pc;
   logic            mem_ack;
   logic            buffer_carry_out;
   logic [4:0]      rd_index, rs1_index, rs2_index;
   logic            write_en, op_enable, data2bus_en, exp_go_up, exp_go_dn;
   logic            buffer_read, buffer_write, inv_en, imm_en, imm_up_en;
   logic            pc_imm_en, pc_plus_en, dataFM_en, carry_in;
   logic [3:0]      op_fa;
   logic [COLS-1:0] immediate, pc_reg, pc_plus4;
   logic            mem_req, mem_we, done, illegal, mem_err, carry_flag;

   always #5 clk = ~clk;

   cim_seq_ctrl #(.COLS(COLS), .MEM_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .pc(pc), .mem_ack(mem_ack), .buffer_carry_out(buffer_carry_out),
      .rd_index(rd_index), .rs1_index(rs1_index), .rs2_index(rs2_index),
      .write_en(write_en), .op_enable(op_enable), .data2bus_en(data2bus_en),
      .exp_go_up(exp_go_up), .exp_go_dn(exp_go_dn), .buffer_read(buffer_read),
      .buffer_write(buffer_write), .inv_en(inv_en), .imm_en(imm_en),
      .imm_up_en(imm_up_en), .pc_imm_en(pc_imm_en), .pc_plus_en(pc_plus_en),
      .dataFM_en(dataFM_en), .carry_in(carry_in), .op_fa(op_fa),
      .immediate(immediate), .pc_reg(pc_reg), .pc_plus4(pc_plus4),
      .mem_req(mem_req), .mem_we(mem_we), .done(done), .illegal(illegal),
      .mem_err(mem_err), .carry_flag(carry_flag)
   );

   typedef struct packed {
      logic we, ope, d2b, eup, edn, brd, bwr, inv, imm, immup, pcimm, pcplus, dfm, cin;
      logic [3:0] fa;
      logic mreq, mwe, dn, ill, merr, rdy;
   } obs_t;

   typedef enum {C_R, C_I, C_SUB, C_LUI, C_AUIPC, C_LW, C_SW, C_ILL} cls_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   logic exp_carry = 1'b0;
   obs_t exp_q[$];

   function automatic obs_t sample();
      obs_t o;
      o = '{we:write_en, ope:op_enable, d2b:data2bus_en, eup:exp_go_up, edn:exp_go_dn,
            brd:buffer_read, bwr:buffer_write, inv:inv_en, imm:imm_en, immup:imm_up_en,
            pcimm:pc_imm_en, pcplus:pc_plus_en, dfm:dataFM_en, cin:carry_in, fa:op_fa,
            mreq:mem_req, mwe:mem_we, dn:done, ill:illegal, merr:mem_err, rdy:instr_ready};
      return o;
   endfunction

   function automatic obs_t idle_obs();
      obs_t o;
      o = '0;
      o.rdy = 1'b1;
      return o;
   endfunction

   function automatic cls_t classify(input logic [31:0] ins);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       alu3;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      alu3 = (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd6) || (f3 == 3'd7);
      if (op == 7'h33 && f7 == 7'h00 && alu3) return C_R;
      if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return C_SUB;
      if (op == 7'h13 && alu3) return C_I;
      if (op == 7'h37) return C_LUI;
      if (op == 7'h17) return C_AUIPC;
      if (op == 7'h03 && f3 == 3'd2) return C_LW;
      if (op == 7'h23 && f3 == 3'd2) return C_SW;
      return C_ILL;
   endfunction

   function automatic logic [3:0] fa_of(input logic [2:0] f3);
      case (f3)
         3'd0:    return 4'b0001;
         3'd7:    return 4'b0010;
         3'd4:    return 4'b0100;
         3'd6:    return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] exp_imm(input logic [31:0] ins, input cls_t c);
      if (c == C_LUI || c == C_AUIPC) return {ins[31:12], 12'h000};
      if (c == C_SW) return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      return {{20{ins[31]}}, ins[31:20]};
   endfunction

   // Expected per-cycle outputs from the accept edge onward; d = memory-wait cycles
   function automatic void model(input logic [31:0] ins, input int d);
      cls_t       c;
      logic       wr;
      logic [3:0] fa;
      obs_t       b;
      c  = classify(ins);
      wr = (ins[11:7] != 5'd0);
      fa = fa_of(ins[14:12]);
      exp_q.delete();
      b = '0;
      case (c)
         C_R:     begin b.ope = 1; b.d2b = 1; b.we = wr; b.fa = fa; b.dn = 1; exp_q.push_back(b); end
         C_I:     begin b.ope = 1; b.imm = 1; b.we = wr; b.fa = fa; b.dn = 1; exp_q.push_back(b); end
         C_LUI:   begin b.immup = 1; b.we = wr; b.dn = 1; exp_q.push_back(b); end
         C_AUIPC: begin b.pcimm = 1; b.we = wr; b.dn = 1; exp_q.push_back(b); end
         C_ILL:   begin b.ill = 1; exp_q.push_back(b); end
         C_SUB: begin
            b.inv = 1; b.fa = 4'b0100; b.d2b = 1; b.bwr = 1;
            exp_q.push_back(b);
            b = '0;
            b.ope = 1; b.brd = 1; b.fa = 4'b0001; b.cin = 1; b.we = wr; b.dn = 1;
            exp_q.push_back(b);
         end
         default: begin
            b.eup = 1; b.ope = 1; b.imm = 1; b.fa = 4'b0001; b.mreq = 1;
            if (c == C_SW) begin b.d2b = 1; b.mwe = 1; end
`ifdef CIM_SEQ_TIMEOUT_EN
            if (d > 64) begin
               for (int k = 0; k < 65; k++) exp_q.push_back(b);
               b = '0; b.merr = 1; b.rdy = 1;
               exp_q.push_back(b);
               return;
            end
`endif
            for (int k = 0; k < d; k++) exp_q.push_back(b);
            if (c == C_SW) begin
               b.dn = 1;
               exp_q.push_back(b);
            end else begin
               exp_q.push_back(b);
               b = '0; b.dfm = 1; b.we = wr; b.dn = 1;
               exp_q.push_back(b);
            end
         end
      endcase
   endfunction

   // Accept one instruction from an IDLE cycle and follow it cycle by cycle
   task automatic run_instr(input logic [31:0] ins, input logic [31:0] p, input int d,
                            input bit early, input bit cy, input string tag);
      cls_t c;
      obs_t o;
      c = classify(ins);
      model(ins, d);
      mem_ack = 1'b0;
      #1;
      o = sample();
      n_checks++;
      if (o !== idle_obs()) $display("FAIL %s idle_before got=%h exp=%h", tag, o, idle_obs());
      else n_pass++;
      n_checks++;
      if (carry_flag !== exp_carry) $display("FAIL %s carry_flag got=%b exp=%b", tag, carry_flag, exp_carry);
      else n_pass++;
      instr_valid = 1'b1; instr = ins; pc = p; buffer_carry_out = cy;
      mem_ack = 1'($urandom);
      @(negedge clk);
      instr_valid = 1'b0; instr = $urandom; pc = $urandom;
      for (int k = 1; k <= exp_q.size(); k++) begin
         if (c == C_LW || c == C_SW) mem_ack = (k == 1 && early) || (k == 1 + d);
         else mem_ack = 1'($urandom);
         #1;
         o = sample();
         n_checks++;
         if (o !== exp_q[k-1]) $display("FAIL %s cycle%0d got=%h exp=%h", tag, k, o, exp_q[k-1]);
         else n_pass++;
         if (k == 1) begin
            n_checks++;
            if ({rd_index, rs1_index, rs2_index, pc_reg, pc_plus4} !== {ins[11:7], ins[19:15], ins[24:20], p, p + 32'd4})
               $display("FAIL %s fields got=%h/%h/%h pc=%h pc4=%h exp=%h/%h/%h pc=%h", tag, rd_index,
                        rs1_index, rs2_index, pc_reg, pc_plus4, ins[11:7], ins[19:15], ins[24:20], p);
            else n_pass++;
            if (c != C_R && c != C_SUB && c != C_ILL) begin
               n_checks++;
               if (immediate !== exp_imm(ins, c)) $display("FAIL %s immediate got=%h exp=%h", tag, immediate, exp_imm(ins, c));
               else n_pass++;
            end
         end
         @(negedge clk);
      end
      mem_ack = 1'b0;
      if (c == C_SUB) exp_carry = cy;
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {im, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
      return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] im;
      logic [2:0]  f3a;
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      im  = 12'($urandom);
      case ($urandom_range(0, 3))
         0:       f3a = 3'd0;
         1:       f3a = 3'd4;
         2:       f3a = 3'd6;
         default: f3a = 3'd7;
      endcase
      case ($urandom_range(0, 9))
         0: return enc_r(7'h00, rs2, rs1, f3a, rd);
         1: return enc_r(7'h20, rs2, rs1, 3'd0, rd);
         2: return enc_i(im, rs1, f3a, rd, 7'h13);
         3: return {20'($urandom), rd, 7'h37};
         4: return {20'($urandom), rd, 7'h17};
         5: return enc_i(im, rs1, 3'b010, rd, 7'h03);
         6: return enc_s(im, rs2, rs1);
         7: return enc_r(($urandom % 2) ? 7'h20 : 7'h01, rs2, rs1, 3'($urandom), rd);
         8: return enc_i(im, rs1, 3'($urandom), rd, 7'h13);
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      obs_t o;
      rst = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0; mem_ack = 1'b0; buffer_carry_out = 1'b0;
      repeat (2) @(negedge clk);
      o = sample();
      n_checks++;
      if (o !== idle_obs()) $display("FAIL reset_outputs got=%h exp=%h", o, idle_obs());
      else n_pass++;
      n_checks++;
      if ({rd_index, rs1_index, rs2_index, immediate, pc_reg, pc_plus4, carry_flag} !== '0)
         $display("FAIL reset_regs got=%h exp=0", {rd_index, rs1_index, rs2_index, immediate, pc_reg, pc_plus4, carry_flag});
      else n_pass++;
      rst = 1'b0;
      exp_carry = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_instr(32'h002081B3, 32'h0000_0100, 0, 0, 0, "add_x3_x1_x2");
      run_instr(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd5), 32'h0000_0104, 0, 0, 1, "sub_x5_x6_x7");
      run_instr(enc_i(12'd8, 5'd2, 3'b010, 5'd4, 7'h03), 32'h0000_0108, 3, 0, 0, "lw_x4_8_x2");
      run_instr(enc_s(12'hFFC, 5'd9, 5'd1), 32'h0000_010C, 2, 0, 0, "sw_x9_m4_x1");
      run_instr(enc_i(12'd1, 5'd0, 3'd0, 5'd0, 7'h13), 32'h0000_0110, 0, 0, 0, "addi_x0");
      run_instr(32'h0000_007F, 32'h0000_0114, 0, 0, 0, "illegal_7f");
      run_instr(enc_i(12'h7F0, 5'd3, 3'b010, 5'd0, 7'h03), 32'h0000_0118, 1, 1, 0, "lw_x0_early_ack");
      run_instr(enc_s(12'h123, 5'd4, 5'd5), 32'h0000_011C, 1, 1, 0, "sw_early_ack");
      run_instr(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd0), 32'h0000_0120, 0, 0, 0, "sub_x0");
   endtask

   task automatic test_back_to_back();
      run_instr(enc_r(7'h00, 5'd2, 5'd3, 3'd7, 5'd4), 32'h0000_0200, 0, 0, 0, "b2b_and");
      run_instr(enc_r(7'h00, 5'd2, 5'd3, 3'd6, 5'd4), 32'h0000_0204, 0, 0, 0, "b2b_or");
      run_instr(enc_r(7'h00, 5'd2, 5'd3, 3'd4, 5'd4), 32'h0000_0208, 0, 0, 0, "b2b_xor");
      run_instr(enc_i(12'h800, 5'd1, 3'd7, 5'd8, 7'h13), 32'h0000_020C, 0, 0, 0, "b2b_andi");
      run_instr(enc_i(12'h055, 5'd1, 3'd6, 5'd8, 7'h13), 32'h0000_0210, 0, 0, 0, "b2b_ori");
      run_instr(enc_i(12'hFFF, 5'd1, 3'd4, 5'd8, 7'h13), 32'h0000_0214, 0, 0, 0, "b2b_xori");
      run_instr({20'hABCDE, 5'd10, 7'h37}, 32'h0000_0218, 0, 0, 0, "b2b_lui");
      run_instr({20'h80001, 5'd11, 7'h17}, 32'h0000_021C, 0, 0, 0, "b2b_auipc");
      run_instr(enc_r(7'h20, 5'd12, 5'd13, 3'd0, 5'd14), 32'h0000_0220, 0, 0, 0, "b2b_sub");
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++)
         run_instr(rand_instr(), $urandom & 32'hFFFF_FFFC, $urandom_range(1, 6),
                   1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
   endtask

   task automatic test_long_wait();
      run_instr(enc_i(12'h010, 5'd3, 3'b010, 5'd7, 7'h03), 32'h0000_0300, 70, 0, 0, "lw_long_wait");
   endtask

   task automatic test_reset_midop();
      obs_t o;
      instr_valid = 1'b1; instr = enc_i(12'd8, 5'd2, 3'b010, 5'd4, 7'h03); pc = 32'h400;
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1) $display("FAIL midop_mem_req_before got=%b exp=1", mem_req);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      o = sample();
      n_checks++;
      if (o !== idle_obs()) $display("FAIL midop_lw_after_rst got=%h exp=%h", o, idle_obs());
      else n_pass++;
      rst = 1'b0;
      exp_carry = 1'b0;
      @(negedge clk);
      instr_valid = 1'b1; instr = enc_s(12'h010, 5'd6, 5'd7); pc = 32'h404;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      mem_ack = 1'b1; rst = 1'b1;
      #1;
      n_checks++;
      if (done !== 1'b0) $display("FAIL midop_sw_done_in_rst got=%b exp=0", done);
      else n_pass++;
      @(negedge clk);
      o = sample();
      n_checks++;
      if (o !== idle_obs()) $display("FAIL midop_sw_after_rst got=%h exp=%h", o, idle_obs());
      else n_pass++;
      rst = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_long_wait();
      test_reset_midop();
      run_instr(enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd3), 32'h0000_0500, 0, 0, 0, "after_reset_add");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
